multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 4: alu_ctrl width; SHALL be >=4, upper bits zero-padded.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  7; funct3  in  3; funct7_5  in  1: fields of the instruction register.
REQ-005 zero, lt, ltu  in  1 each: ALU flags (equal, signed less-than, unsigned less-than) of the current ALU operation.
REQ-006 mem_ready  in  1: memory completes the current access this cycle.
REQ-007 pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, adr_src  out  1 each: PC load, IR load, regfile write, memory write, memory read, address select (0=PC, 1=ALUOut).
REQ-008 alu_src_a  out  2 (00 PC, 01 oldPC, 10 rs1); alu_src_b  out  2 (00 rs2, 01 imm, 10 const 4); result_src  out  2 (00 ALUOut, 01 read data, 10 ALU result).
REQ-009 imm_src  out  3 (000 I, 001 S, 010 B, 011 J, 100 U); alu_ctrl  out  ALUCTRL_W.
REQ-010 illegal  out  1: sticky unsupported-instruction flag; state  out  4: current state code (debug).

Function
REQ-011 Moore FSM, states/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRPC 12, LUI 13, TRAP 14; outputs decode from state only, except pc_wr/ir_wr (mem_ready, branch outcome).
REQ-012 alu_ctrl codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass_b.
REQ-013 FETCH: mem_rd=1, adr_src=0, a=PC, b=4, add, result_src=10; ir_wr=pc_wr=mem_ready; stays until mem_ready=1, then DECODE.
REQ-014 DECODE: a=oldPC, b=imm, add; imm_src from op; next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, any other TRAP.
REQ-015 MEMADR: a=rs1, b=imm, add; imm_src I for load, S for store; next MEMREAD (load) or MEMWRITE (store).
REQ-016 MEMREAD: mem_rd=1, adr_src=1; holds until mem_ready, then MEMWB. MEMWB: result_src=01, reg_wr=1, then FETCH.
REQ-017 MEMWRITE: mem_wr=1, adr_src=1; holds until mem_ready, then FETCH; mem_wr SHALL stay high while waiting.
REQ-018 EXECR: a=rs1, b=rs2; alu_ctrl by funct3: 000 add (sub if funct7_5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct7_5), 110 or, 111 and; next ALUWB.
REQ-019 EXECI: as EXECR with b=imm, imm_src I; funct3=000 always add; funct7_5 honoured only for funct3=101; next ALUWB.
REQ-020 ALUWB: result_src=00, reg_wr=1, then FETCH.
REQ-021 BRANCH: a=rs1, b=rs2, sub, result_src=00 (target from DECODE); pc_wr=taken; next FETCH. taken: funct3 000 zero, 001 !zero.
REQ-022 JAL: pc_wr=1, result_src=00, a=oldPC, b=4, add; next ALUWB (rd=PC+4).
REQ-023 JALR: a=rs1, b=imm, add, next JALRPC; JALRPC: pc_wr=1, result_src=00, a=oldPC, b=4, add; next ALUWB.
REQ-024 LUI: b=imm, imm_src U, pass_b; next ALUWB.
REQ-025 TRAP: all write strobes 0, illegal=1; state held until reset.
REQ-026 Cycle counts with mem_ready=1: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI 4; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=FETCH, illegal=0, and combinationally force pc_wr, ir_wr, reg_wr, mem_wr, mem_rd to 0.
REQ-028 Reset asserted mid-instruction (any state, including TRAP or memory wait) SHALL abort it; first FETCH after deassertion behaves as REQ-013.

Configuration
REQ-029 Macro BRANCH_EXT_EN defined: BRANCH taken also for funct3 100 lt, 101 !lt, 110 ltu, 111 !ltu.
REQ-030 BRANCH_EXT_EN undefined: lt/ltu ignored; branch op with funct3 not 000/001 SHALL go DECODE->TRAP.

Verification
REQ-031 Reset, then op=0000011, mem_ready=1 -> states 0,1,2,3,4,0; reg_wr=1 only in MEMWB with result_src=01.
REQ-032 op=0110011, funct3=101, funct7_5=1 -> EXECR alu_ctrl=9, ALUWB reg_wr=1; 4 cycles total.
REQ-033 op=0100011, mem_ready low 3 cycles in MEMWRITE -> mem_wr high 4 consecutive cycles, then FETCH.
REQ-034 op=1100011, funct3=001, zero=0 -> pc_wr=1 in BRANCH; zero=1 -> pc_wr=0; next FETCH both cases.
REQ-035 op=1100011, funct3=100, lt=1 -> with BRANCH_EXT_EN pc_wr=1; without -> TRAP, illegal=1 until rst_n=0.
REQ-036 op=0000000 -> TRAP; rst_n pulsed low in TRAP -> state=0, illegal=0 immediately, no write strobe.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle RV32 datapath (load/store, ALU, branch, JAL/JALR, LUI).
// Define BRANCH_EXT_EN to add the blt/bge/bltu/bgeu branch conditions.
module multicycle_control_unit #(
  parameter int unsigned ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 pc_wr,
  output logic                 ir_wr,
  output logic                 reg_wr,
  output logic                 mem_wr,
  output logic                 mem_rd,
  output logic                 adr_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrPc   = 4'd12,
    StLui      = 4'd13,
    StTrap     = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluPassB
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  state_e  state_q, state_d;
  logic    illegal_q;
  logic    branch_ok, branch_taken;
  alu_op_e alu_op;

  // funct7_5 selects sub only for register ops; it always selects sra for shifts.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

`ifdef BRANCH_EXT_EN
  always_comb begin
    branch_ok    = (funct3[2:1] != 2'b01);
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = !ltu;
      default: branch_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = lt ^ ltu;

  always_comb begin
    branch_ok    = (funct3[2:1] == 2'b00);
    branch_taken = funct3[0] ? !zero : zero;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = branch_ok ? StBranch : StTrap;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StMemWb, StAluWb, StBranch: state_d = StFetch;
      StExecR, StExecI, StJal, StLui, StJalrPc: state_d = StAluWb;
      StJalr:     state_d = StJalrPc;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    alu_op     = AluAdd;
    case (state_q)
      StFetch: begin
        mem_rd     = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_wr      = mem_ready;
        pc_wr      = mem_ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpStore:  imm_src = 3'b001;
          OpBranch: imm_src = 3'b010;
          OpJal:    imm_src = 3'b011;
          OpLui:    imm_src = 3'b100;
          default:  imm_src = 3'b000;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OpStore) ? 3'b001 : 3'b000;
      end
      StMemRead: begin
        mem_rd  = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        reg_wr     = 1'b1;
        result_src = 2'b01;
      end
      StMemWrite: begin
        mem_wr  = 1'b1;
        adr_src = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = arith_op(funct3, funct7_5, 1'b1);
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = arith_op(funct3, funct7_5, 1'b0);
      end
      StAluWb:  reg_wr = 1'b1;
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = AluSub;
        pc_wr     = branch_taken;
      end
      StJal, StJalrPc: begin
        pc_wr     = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StJalr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StLui: begin
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        alu_op    = AluPassB;
      end
      default: ;
    endcase
    // FETCH strobes follow mem_ready, so reset must mask them directly.
    if (!rst_n) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      reg_wr = 1'b0;
      mem_wr = 1'b0;
      mem_rd = 1'b0;
    end
  end

  assign alu_ctrl = ALUCTRL_W'(alu_op);
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction state-path model with
// randomized memory stalls and ALU flags.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail = 0;

  multicycle_control_unit #(.ALUCTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic bit branch_legal(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return (f3 <= 3'd1) || (f3 >= 3'd4);
`else
    return f3 <= 3'd1;
`endif
  endfunction

  function automatic logic taken_ref(input logic [2:0] f3, input logic z, input logic l,
                                     input logic lu);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
`ifdef BRANCH_EXT_EN
    if (f3 == 3'd4) return l;
    if (f3 == 3'd5) return !l;
    if (f3 == 3'd6) return lu;
    if (f3 == 3'd7) return !lu;
`endif
    return 1'b0;
  endfunction

  // Spec ALU codes: 0 add 1 sub 2 and 3 or 4 xor 5 slt 6 sltu 7 sll 8 srl 9 sra 10 pass_b
  function automatic int alu_ref(input logic [2:0] f3, input logic f7, input bit is_r);
    int tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int r = tab[f3];
    if (f3 == 3'd0 && is_r && f7) r = 1;
    if (f3 == 3'd5 && f7) r = 9;
    return r;
  endfunction

  function automatic int dec_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b1100111, 7'b0010011: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b0110111: return 4;
      default:    return -1;
    endcase
  endfunction

  function automatic int base_cycles(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b1100111: return 5;
      7'b1100011: return 3;
      default:    return 4;
    endcase
  endfunction

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_%s: state/illegal/strobes got=%b required=%b", tag,
               {state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd}, 10'b0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  // stall_mode: 0 none, 1 random, 2 hold mem_ready low for 3 MEMWRITE cycles.
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic f7,
                           input int stall_mode, input bit rand_flags, input logic fz,
                           input logic flt, input logic fltu, output int wr_cycles);
    int   path[$];
    int   idx = 0, stalls = 0, cycles = 0, guard = 0, hold = 0, st;
    logic e_pc, e_ir, e_reg, e_mw, e_mr, e_adr;
    int   ea, eb, er, ei, eal;
    wr_cycles = 0;
    case (iop)
      7'b0000011: path = '{0, 1, 2, 3, 4};
      7'b0100011: path = '{0, 1, 2, 5};
      7'b0110011: path = '{0, 1, 6, 8};
      7'b0010011: path = '{0, 1, 7, 8};
      7'b1100011: if (branch_legal(f3)) path = '{0, 1, 9}; else path = '{0, 1, 14};
      7'b1101111: path = '{0, 1, 10, 8};
      7'b1100111: path = '{0, 1, 11, 12, 8};
      7'b0110111: path = '{0, 1, 13, 8};
      default:    path = '{0, 1, 14};
    endcase
    while (idx < path.size() && guard < 100) begin
      @(negedge clk);
      guard++;
      st = path[idx];
      op = iop; funct3 = f3; funct7_5 = f7;
      case (stall_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 2) != 0);
        default: mem_ready = !(st == 5 && hold < 3);
      endcase
      if (rand_flags) begin
        zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
      end else begin
        zero = fz; lt = flt; ltu = fltu;
      end
      #1;
      {e_pc, e_ir, e_reg, e_mw, e_mr, e_adr} = 6'b0;
      ea = -1; eb = -1; er = -1; ei = -1; eal = -1;
      case (st)
        0:  begin e_mr = 1; e_pc = mem_ready; e_ir = mem_ready; ea = 0; eb = 2; eal = 0; er = 2; end
        1:  begin ea = 1; eb = 1; eal = 0; ei = dec_imm(iop); end
        2:  begin ea = 2; eb = 1; eal = 0; ei = (iop == 7'b0100011) ? 1 : 0; end
        3:  begin e_mr = 1; e_adr = 1; end
        4:  begin e_reg = 1; er = 1; end
        5:  begin e_mw = 1; e_adr = 1; end
        6:  begin ea = 2; eb = 0; eal = alu_ref(f3, f7, 1'b1); end
        7:  begin ea = 2; eb = 1; ei = 0; eal = alu_ref(f3, f7, 1'b0); end
        8:  begin e_reg = 1; er = 0; end
        9:  begin ea = 2; eb = 0; eal = 1; er = 0; e_pc = taken_ref(f3, zero, lt, ltu); end
        10, 12: begin e_pc = 1; er = 0; ea = 1; eb = 2; eal = 0; end
        11: begin ea = 2; eb = 1; eal = 0; end
        13: begin eb = 1; ei = 4; eal = 10; end
        default: ;
      endcase
      n_checks++;
      if ({state, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, adr_src, illegal} !==
          {4'(st), e_pc, e_ir, e_reg, e_mw, e_mr, e_adr, (st == 14)}) begin
        n_fail++;
        $display("FAIL ctrl op=%b f3=%0d st=%0d: {state,pc,ir,reg,mw,mr,adr,ill} got=%b required=%b",
                 iop, f3, st, {state, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, adr_src, illegal},
                 {4'(st), e_pc, e_ir, e_reg, e_mw, e_mr, e_adr, (st == 14)});
      end
      if (ea >= 0) begin
        n_checks++;
        if ({alu_src_a, alu_src_b} !== {2'(ea), 2'(eb)}) begin
          n_fail++;
          $display("FAIL alu_src st=%0d: a,b got=%0d,%0d required=%0d,%0d", st, alu_src_a,
                   alu_src_b, ea, eb);
        end
      end
      if (eal >= 0) begin
        n_checks++;
        if (alu_ctrl !== 4'(eal)) begin
          n_fail++;
          $display("FAIL alu_ctrl st=%0d f3=%0d f7=%b: got=%0d required=%0d", st, f3, f7,
                   alu_ctrl, eal);
        end
      end
      if (er >= 0) begin
        n_checks++;
        if (result_src !== 2'(er)) begin
          n_fail++;
          $display("FAIL result_src st=%0d: got=%0d required=%0d", st, result_src, er);
        end
      end
      if (ei >= 0) begin
        n_checks++;
        if (imm_src !== 3'(ei)) begin
          n_fail++;
          $display("FAIL imm_src st=%0d op=%b: got=%0d required=%0d", st, iop, imm_src, ei);
        end
      end
      cycles++;
      if (mem_wr === 1'b1) wr_cycles++;
      if ((st == 0 || st == 3 || st == 5) && !mem_ready) begin
        stalls++;
        if (st == 5) hold++;
      end else begin
        idx++;
      end
    end
    if (guard >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL path_timeout op=%b: got %0d cycles, required path end", iop, guard);
    end
    if (path[path.size()-1] != 14) begin
      n_checks++;
      if (cycles != base_cycles(iop) + stalls) begin
        n_fail++;
        $display("FAIL cycle_count op=%b: got=%0d required=%0d", iop, cycles,
                 base_cycles(iop) + stalls);
      end
    end else begin
      repeat (3) begin
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd} !== {4'd14, 1'b1, 5'b0}) begin
          n_fail++;
          $display("FAIL trap_hold op=%b: {state,ill,strobes} got=%b required=%b", iop,
                   {state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd}, {4'd14, 1'b1, 5'b0});
        end
      end
      pulse_reset("trap");
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_init: got=%b required=%b",
               {state, illegal, pc_wr, ir_wr, reg_wr, mem_wr, mem_rd}, 10'b0);
    end
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, pc_wr, ir_wr, mem_rd} !== {4'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL fetch_wait: {state,pc,ir,rd} got=%b required=%b",
               {state, pc_wr, ir_wr, mem_rd}, {4'd0, 3'b001});
    end
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; funct3 = 3'd2; funct7_5 = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, mem_rd, adr_src} !== {4'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL memread_wait: {state,rd,adr} got=%b required=%b",
               {state, mem_rd, adr_src}, {4'd3, 2'b11});
    end
    pulse_reset("mid");
  endtask

  task automatic test_load();
    int w;
    run_instr(7'b0000011, 3'd2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, w);
  endtask

  task automatic test_r_sra();
    int w;
    run_instr(7'b0110011, 3'd5, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, w);
    run_instr(7'b0010011, 3'd0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, w);
  endtask

  task automatic test_store_stall();
    int w;
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, w);
    n_checks++;
    if (w != 4) begin
      n_fail++;
      $display("FAIL store_mem_wr_cycles: got=%0d required=4", w);
    end
  endtask

  task automatic test_branch();
    int w;
    run_instr(7'b1100011, 3'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, w);
    run_instr(7'b1100011, 3'd1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, w);
    run_instr(7'b1100011, 3'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, w);
    run_instr(7'b1100011, 3'd4, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, w);
    run_instr(7'b1100011, 3'd7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, w);
  endtask

  task automatic test_trap();
    int w;
    run_instr(7'b0000000, 3'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    logic [6:0] o;
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom), 1, 1'b1, 1'b0, 1'b0, 1'b0, w);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_r_sra();
    test_store_stall();
    test_branch();
    test_trap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
